// File: rtl/sort_job_arbiter.sv
// sort_job_arbiter: round-robin front end that shares one sort engine between
// NREQ requesters. A job is accepted in IDLE, launched with a one-cycle start
// pulse, tracked against a timeout while the engine runs, and its result is
// held until the consumer accepts it.
module sort_job_arbiter #(
   parameter int NREQ    = 4,
   parameter int N       = 6,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 32,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NREQ-1:0]                   req_valid,
   input  logic [NREQ-1:0][N*WIDTH-1:0]      req_data,
   output logic [NREQ-1:0]                   req_ready,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [IDW-1:0]                    rsp_id,
   output logic [N*WIDTH-1:0]                rsp_data,
   output logic                              rsp_err,
   output logic                              eng_start,
   output logic [N*WIDTH-1:0]                eng_data,
   input  logic                              eng_done,
   input  logic [N*WIDTH-1:0]                eng_sorted,
   output logic                              busy,
   output logic                              timeout_sticky
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [N*WIDTH-1:0]   job_buf_q, job_buf_d;
   logic [IDW-1:0]       job_id_q, job_id_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 start_q, start_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   logic [N*WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 sticky_q, sticky_d;

   logic                 win_found;
   logic [IDW-1:0]       win_idx;
   logic [IDW-1:0]       win_next;
   logic [IDW:0]         cand_sum;
   logic [IDW-1:0]       cand;

   // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (cand_sum >= (IDW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NREQ);
         end
         cand = cand_sum[IDW-1:0];
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_next = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
   end

   // One-hot grant to the winner, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && !rst && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // State and datapath registers; async active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         job_buf_q  <= '0;
         job_id_q   <= '0;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         job_buf_q  <= job_buf_d;
         job_id_q   <= job_id_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         sticky_q   <= sticky_d;
      end
   end

   // Next-state logic: accept, launch, run with timeout, hold response.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      job_buf_d  = job_buf_q;
      job_id_d   = job_id_q;
      cnt_d      = cnt_q;
      start_d    = 1'b0;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      sticky_d   = sticky_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               job_buf_d = req_data[win_idx];
               job_id_d  = win_idx;
               rr_ptr_d  = win_next;
               // start is registered, so raising it here makes it high exactly in LAUNCH
               start_d   = 1'b1;
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (eng_done) begin
               rsp_data_d = eng_sorted;
               rsp_id_d   = job_id_q;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               rsp_data_d = '0;
               rsp_id_d   = job_id_q;
               rsp_err_d  = 1'b1;
               sticky_d   = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign eng_start      = start_q;
   assign eng_data       = job_buf_q;
   assign rsp_valid      = (state_q == S_RESP);
   assign rsp_id         = rsp_id_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign busy           = (state_q != S_IDLE);
   assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Scoreboard bench for sort_job_arbiter with a behavioural sort-engine stub.
module tb_sort_job_arbiter;

   localparam int NREQ    = 4;
   localparam int N       = 6;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 32;
   localparam int IDW     = 2;
   localparam int VW      = N * WIDTH;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][VW-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [VW-1:0]         rsp_data;
   logic                  rsp_err;
   logic                  eng_start;
   logic [VW-1:0]         eng_data;
   logic                  eng_done;
   logic [VW-1:0]         eng_sorted;
   logic                  busy;
   logic                  timeout_sticky;

   sort_job_arbiter #(
      .NREQ(NREQ),
      .N(N),
      .WIDTH(WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id(rsp_id),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .eng_start(eng_start),
      .eng_data(eng_data),
      .eng_done(eng_done),
      .eng_sorted(eng_sorted),
      .busy(busy),
      .timeout_sticky(timeout_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // Reference sort: ascending, element 0 smallest.
   function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
      int q[$];
      logic [VW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) q.push_back(int'(v[k*WIDTH +: WIDTH]));
      q.sort();
      for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'(q[k]);
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
      return r;
   endfunction

   function automatic int winner(input logic [NREQ-1:0] v, input int rr);
      for (int i = 0; i < NREQ; i++) begin
         int j;
         j = (rr + i) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   // ---------------- sort engine stub ----------------
   int   eng_lat = 8;     // latency for the next job (0 = never done)
   int   job_lat = 8;     // latency captured when the job was accepted
   int   e_lat, e_cnt;
   bit   e_run;
   logic e_prev, e_done_r;
   bit   force_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_prev     <= 1'b0;
         e_run      <= 1'b0;
         e_cnt      <= 0;
         e_lat      <= 0;
         e_done_r   <= 1'b0;
         eng_sorted <= '0;
      end else begin
         e_prev <= eng_start;
         if (eng_start && !e_prev) begin
            e_lat    <= job_lat;
            e_cnt    <= 1;
            e_done_r <= (job_lat == 1);
            if (job_lat == 1) eng_sorted <= sort_vec(eng_data);
            e_run    <= (job_lat > 1);
         end else if (e_run) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt + 1 == e_lat) begin
               e_done_r   <= 1'b1;
               eng_sorted <= sort_vec(eng_data);
               e_run      <= 1'b0;
            end
         end
      end
   end
   assign eng_done = e_done_r | force_done;

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int            id;
      logic [VW-1:0] data;
      bit            err;
      int            rcyc;
   } exp_t;

   exp_t sb[$];
   int   acc_log[$];
   bit   pending = 1'b0;
   bit   front_seen = 1'b0;
   bit   m_sticky = 1'b0;
   int   m_rr = 0;
   int   exp_start = -1;

   always @(negedge clk) begin
      int              w;
      bit              xfer;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] xd;
      exp_t            it;
      if (!rst) begin
         w = winner(req_valid, m_rr);
         xfer = !pending && (w >= 0);
         exp_rdy = '0;
         if (xfer) exp_rdy[w] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(pending));
         chk("eng_start", 64'(eng_start), 64'(cyc == exp_start));
         xd = req_valid & req_ready;
         for (int k = 0; k < NREQ; k++) if (xd[k]) acc_log.push_back(k);

         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
               if (!front_seen) begin
                  front_seen = 1'b1;
                  chk("rsp_latency", 64'(cyc), 64'(sb[0].rcyc));
                  if (sb[0].err) m_sticky = 1'b1;
               end
               chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
               chk("rsp_data", 64'(rsp_data), 64'(sb[0].data));
               chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  front_seen = 1'b0;
                  pending = 1'b0;
               end
            end
         end
         chk("timeout_sticky", 64'(timeout_sticky), 64'(m_sticky));

         if (xfer) begin
            job_lat = eng_lat;
            it.id   = w;
            it.err  = (eng_lat == 0) || (eng_lat > TIMEOUT);
            it.data = it.err ? '0 : sort_vec(req_data[w]);
            it.rcyc = it.err ? cyc + TIMEOUT + 2 : cyc + eng_lat + 2;
            sb.push_back(it);
            exp_start = cyc + 1;
            m_rr = (w + 1) % NREQ;
            pending = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit refill = 1'b0;

   task automatic tick();
      logic [NREQ-1:0] xs;
      @(negedge clk);
      xs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int g = 0; g < NREQ; g++) begin
         if (xs[g]) begin
            if (refill) req_data[g] = rand_vec();
            else req_valid[g] = 1'b0;
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (sb.size() == 0 && !pending && req_valid == '0) return;
         tick();
      end
      chk("drain_timeout", 64'(sb.size()), 64'(0));
   endtask

   task automatic model_reset();
      sb.delete();
      acc_log.delete();
      pending = 1'b0;
      front_seen = 1'b0;
      m_sticky = 1'b0;
      m_rr = 0;
      exp_start = -1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
      chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
      chk({tag, "_eng_start"}, 64'(eng_start), 64'(0));
      chk({tag, "_eng_data"}, 64'(eng_data), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_sticky"}, 64'(timeout_sticky), 64'(0));
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_all_zero(tag);
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  sj[6];
      bit  seen;
      logic [NREQ-1:0] nv;
      sj = '{5, 3, 9, 1, 7, 2};
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;

      // single job from requester 0
      for (int k = 0; k < N; k++) req_data[0][k*WIDTH +: WIDTH] = WIDTH'(sj[k]);
      eng_lat = 8;
      req_valid[0] = 1'b1;
      wait_drain(60);

      // round-robin fairness with all requesters continuously valid
      async_reset("idle_reset");
      for (int g = 0; g < NREQ; g++) req_data[g] = rand_vec();
      refill = 1'b1;
      req_valid = '1;
      for (int k = 0; k < 300 && acc_log.size() < 5; k++) tick();
      refill = 1'b0;
      req_valid = '0;
      wait_drain(60);
      chk("rr_count", 64'(acc_log.size() >= 5), 64'(1));
      if (acc_log.size() >= 5)
         for (int k = 0; k < 5; k++) chk("rr_order", 64'(acc_log[k]), 64'(k % NREQ));

      // backpressure with competing requesters
      rsp_ready = 1'b0;
      req_data[2] = rand_vec();
      req_valid[2] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         seen = rsp_valid;
      end
      chk("bp_rsp_seen", 64'(seen), 64'(1));
      req_data[0] = rand_vec();
      req_data[3] = rand_vec();
      req_valid[0] = 1'b1;
      req_valid[3] = 1'b1;
      repeat (20) tick();
      rsp_ready = 1'b1;
      wait_drain(200);

      // timeout, late done, then normal completion
      eng_lat = 0;
      req_data[1] = rand_vec();
      req_valid[1] = 1'b1;
      wait_drain(100);
      eng_lat = 40;
      req_data[2] = rand_vec();
      req_valid[2] = 1'b1;
      wait_drain(100);
      eng_lat = 8;
      req_data[3] = rand_vec();
      req_valid[3] = 1'b1;
      wait_drain(60);

      // done on the last allowed cycle, and one cycle earlier
      eng_lat = TIMEOUT;
      req_data[0] = rand_vec();
      req_valid[0] = 1'b1;
      wait_drain(100);
      eng_lat = TIMEOUT - 1;
      req_data[1] = rand_vec();
      req_valid[1] = 1'b1;
      wait_drain(100);

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 9))
            0: eng_lat = 0;
            1: eng_lat = TIMEOUT + 1;
            2: eng_lat = TIMEOUT;
            default: eng_lat = int'($urandom_range(1, 12));
         endcase
         nv = NREQ'($urandom_range(0, 15));
         for (int g = 0; g < NREQ; g++) begin
            if (nv[g] && !req_valid[g]) begin
               req_data[g] = rand_vec();
               req_valid[g] = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 15)) tick();
      end
      rsp_ready = 1'b1;
      wait_drain(2000);

      // asynchronous reset while the engine is running
      eng_lat = 20;
      req_data[0] = rand_vec();
      req_valid[0] = 1'b1;
      for (int k = 0; k < 20 && !(pending && cyc >= exp_start + 3); k++) tick();
      chk("run_reached", 64'(pending && busy), 64'(1));
      async_reset("run_reset");
      req_valid = '0;
      force_done = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stale_done_rsp_valid", 64'(rsp_valid), 64'(0));
         chk("stale_done_busy", 64'(busy), 64'(0));
      end
      @(posedge clk);
      #1 force_done = 1'b0;
      eng_lat = 8;
      req_data[3] = rand_vec();
      req_valid[3] = 1'b1;
      wait_drain(60);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sort_job_arbiter.md
Name: sort_job_arbiter

Overview:
- Shares one N-entry sort engine between NREQ requesters. Requesters hand over whole vectors with a valid/ready handshake.
- Round-robin arbitration picks one job at a time. The block latches the job's vector, launches the engine with a single-cycle start pulse, waits for done, and returns the sorted vector tagged with the requester ID.
- Sits between requester front-ends and the sort engine. It is the only driver of the engine's start and data_in.

Parameters:
NREQ, 4, number of requesters (>=2)
N, 6, elements per vector; must match the engine
WIDTH, 8, bits per element
TIMEOUT, 32, max cycles in RUN before the job is aborted
IDW, $clog2(NREQ), requester ID width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester job valid
req_data  in  NREQ x N x WIDTH  per-requester unsorted vector
req_ready  out  NREQ  one-hot accept; transfer = req_valid[g] & req_ready[g]
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  requester index of the result
rsp_data  out  N x WIDTH  sorted vector (all zero when rsp_err)
rsp_err  out  1  job aborted by timeout
eng_start  out  1  engine start; the engine detects the rising edge
eng_data  out  N x WIDTH  engine data_in; held stable from LAUNCH through RUN
eng_done  in  1  engine done level
eng_sorted  in  N x WIDTH  engine data_sorted
busy  out  1  state != IDLE
timeout_sticky  out  1  set on any timeout; cleared only by rst

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0; eng_start=0; eng_data=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; timeout_sticky=0; req_ready=0.
- Reset mid-job abandons the job. No response is produced. The engine must be reset by the same rst.
- States: IDLE -> LAUNCH -> RUN -> RESP -> IDLE.
- IDLE:
  - Winner g = first index with req_valid set, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other bits 0. req_ready is 0 in every non-IDLE state.
  - On transfer: job_buf<=req_data[g], job_id<=g, rr_ptr<=(g+1) mod NREQ, go to LAUNCH.
  - With no req_valid, stay in IDLE and leave rr_ptr unchanged.
- LAUNCH (1 cycle): eng_start=1; eng_data=job_buf; cnt<=0; go to RUN.
- RUN:
  - eng_start=0; eng_data holds.
  - eng_done=1: rsp_data<=eng_sorted, rsp_id<=job_id, rsp_err<=0, go to RESP.
  - Else if cnt==TIMEOUT-1: rsp_data<=0, rsp_id<=job_id, rsp_err<=1, timeout_sticky<=1, go to RESP.
  - Else cnt<=cnt+1.
  - If eng_done and the timeout coincide, done wins and no error is raised.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE.
  - Backpressure is unbounded.
- eng_start is registered (1 exactly in the LAUNCH cycle). It is always low for at least 1 cycle before any rise, so every launch is a clean edge.
- eng_done is sampled only in RUN. A stale done seen in IDLE, LAUNCH or RESP is ignored.
- Nominal engine latency: eng_done rises 8 cycles after the eng_start cycle.
  - Accept at T: LAUNCH at T+1, eng_done at T+9, rsp_valid at T+10.
  - With rsp_ready held high, the next accept is at T+11.
- Width: cnt is $clog2(TIMEOUT)+1 bits. rr_ptr wraps from NREQ-1 to 0.

Test Plan:
- Single job: req 0 with {5,3,9,1,7,2}, rsp_ready=1 -> req_ready[0] same cycle; eng_start 1-cycle pulse; rsp_valid at T+10 with rsp_id=0, rsp_data={1,2,3,5,7,9}, rsp_err=0.
- Round-robin fairness: all 4 req_valid held high -> accept order 0,1,2,3,0; no requester is granted twice before the others are served.
- Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0 and no eng_start is issued; release -> IDLE next cycle.
- Timeout: stub engine never asserts done, TIMEOUT=32 -> rsp_valid 33 cycles after LAUNCH with rsp_err=1, rsp_data=0, timeout_sticky=1; the next job completes normally.
- Done/timeout tie: done asserted on cycle cnt==TIMEOUT-1 -> rsp_err=0 and rsp_data equals eng_sorted.
- Async reset asserted in RUN -> all outputs zero immediately, state IDLE; a stale eng_done after release produces no response.
